// File: rtl/game_pkg.sv
// Shared types for the round sequencer: phase encoding read by the HUD and
// the winner codes latched at the end of a round.
package game_pkg;

  typedef enum logic [1:0] {
    TITLE     = 2'd0,
    COUNTDOWN = 2'd1,
    PLAY      = 2'd2,
    GAMEOVER  = 2'd3
  } phase_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

endpackage

// File: rtl/round_controller_if.sv
// Signals between the round sequencer, the start key, the two players and the HUD.
interface round_controller_if;

  logic       Start;
  logic [6:0] P1Score;
  logic [6:0] P2Score;
  logic       SpawnEnable;
  logic [2:0] Speed;
  logic [1:0] Phase;
  logic [6:0] SecondsLeft;
  logic [1:0] Winner;
  logic [6:0] FinalP1;
  logic [6:0] FinalP2;

  modport master (
    output Start, P1Score, P2Score,
    input  SpawnEnable, Speed, Phase, SecondsLeft, Winner, FinalP1, FinalP2
  );

  modport slave (
    input  Start, P1Score, P2Score,
    output SpawnEnable, Speed, Phase, SecondsLeft, Winner, FinalP1, FinalP2
  );

endinterface

// File: rtl/sec_timer.sv
// Frame divider: counts FRAMES_PER_SEC frames while running and pulses Tick
// on the frame the count wraps.
module sec_timer #(
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic FrameClk,
  input  logic ResetN,
  input  logic Clear,
  input  logic Run,
  output logic Tick
);

  localparam int CNT_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAMES_PER_SEC - 1);

  logic [CNT_W-1:0] cnt;

  assign Tick = Run && (cnt == LAST);

  // Clear wins over Run so the first Tick after a phase change is a full second away.
  always_ff @(posedge FrameClk or negedge ResetN) begin
    if (!ResetN) begin
      cnt <= '0;
    end else if (Clear) begin
      cnt <= '0;
    end else if (Run) begin
      cnt <= Tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/round_controller.sv
// Game sequencer for both players: Title -> Countdown -> Play -> GameOver,
// with round timer, speed ramp and end-of-round score/winner latch.
module round_controller
  import game_pkg::*;
#(
  parameter int FRAMES_PER_SEC = 60,
  parameter int COUNTDOWN_SECS = 3,
  parameter int ROUND_SECS     = 90,
  parameter int GAMEOVER_SECS  = 10,
  parameter int WIN_SCORE      = 99,
  parameter int BASE_SPEED     = 4,
  parameter int MAX_SPEED      = 7,
  parameter int RAMP_SECS      = 30
) (
  input logic               FrameClk,
  input logic               ResetN,
  round_controller_if.slave bus
);

  localparam logic [6:0] COUNT_V = 7'(COUNTDOWN_SECS);
  localparam logic [6:0] ROUND_V = 7'(ROUND_SECS);
  localparam logic [6:0] OVER_V  = 7'(GAMEOVER_SECS);
  localparam logic [6:0] WIN_V   = 7'(WIN_SCORE);
  localparam logic [6:0] RAMP_V  = 7'(RAMP_SECS);
  localparam logic [2:0] BASE_V  = 3'(BASE_SPEED);
  localparam logic [2:0] MAX_V   = 3'(MAX_SPEED);

  phase_t     state, state_nxt;
  logic       start_q, start_rise;
  logic       tick, clear, run;
  logic       win_hit, last_sec;
  logic [6:0] secs, ramp;
  logic [2:0] speed;
  logic       spawn;
  logic [1:0] winner, winner_cmp;
  logic [6:0] fin_p1, fin_p2;

  function automatic logic [2:0] speed_up(input logic [2:0] s);
    logic [3:0] inc;
    inc = {1'b0, s} + 4'd1;
    if (inc >= {1'b0, MAX_V}) return MAX_V;
    return inc[2:0];
  endfunction

  assign start_rise = bus.Start & ~start_q;
  assign win_hit    = (bus.P1Score >= WIN_V) || (bus.P2Score >= WIN_V);
  assign last_sec   = tick && (secs == 7'd1);
  assign run        = (state != TITLE);
  assign clear      = (state_nxt != state);

  sec_timer #(
    .FRAMES_PER_SEC(FRAMES_PER_SEC)
  ) u_sec_timer (
    .FrameClk(FrameClk),
    .ResetN  (ResetN),
    .Clear   (clear),
    .Run     (run),
    .Tick    (tick)
  );

  always_comb begin
    state_nxt  = state;
    winner_cmp = WIN_TIE;
    if (bus.P1Score > bus.P2Score) winner_cmp = WIN_P1;
    else if (bus.P2Score > bus.P1Score) winner_cmp = WIN_P2;

    case (state)
      TITLE:     if (start_rise) state_nxt = COUNTDOWN;
      COUNTDOWN: if (last_sec) state_nxt = PLAY;
      PLAY:      if (win_hit || last_sec) state_nxt = GAMEOVER;
      GAMEOVER: begin
        // A rematch key press beats the timeout back to Title.
        if (start_rise) state_nxt = COUNTDOWN;
        else if (last_sec) state_nxt = TITLE;
      end
      default:   state_nxt = TITLE;
    endcase
  end

  always_ff @(posedge FrameClk or negedge ResetN) begin
    if (!ResetN) begin
      state   <= TITLE;
      start_q <= 1'b0;
      spawn   <= 1'b0;
      secs    <= '0;
      ramp    <= '0;
      speed   <= BASE_V;
      winner  <= WIN_NONE;
      fin_p1  <= '0;
      fin_p2  <= '0;
    end else begin
      state   <= state_nxt;
      start_q <= bus.Start;
      spawn   <= (state_nxt == PLAY);

      if (state_nxt != state) begin
        case (state_nxt)
          COUNTDOWN: begin
            secs   <= COUNT_V;
            speed  <= BASE_V;
            winner <= WIN_NONE;
            fin_p1 <= '0;
            fin_p2 <= '0;
          end
          PLAY: begin
            secs <= ROUND_V;
            ramp <= '0;
          end
          GAMEOVER: begin
            // Capture before SpawnEnable drops and the players zero their scores.
            secs   <= OVER_V;
            fin_p1 <= bus.P1Score;
            fin_p2 <= bus.P2Score;
            winner <= winner_cmp;
          end
          default: secs <= '0;
        endcase
      end else if (tick && (secs != '0)) begin
        secs <= secs - 7'd1;
      end

      // The ramp also advances on the expiry tick, so the last step lands at round end.
      if ((state == PLAY) && tick) begin
        if ((ramp + 7'd1) == RAMP_V) begin
          ramp  <= '0;
          speed <= speed_up(speed);
        end else begin
          ramp <= ramp + 7'd1;
        end
      end
    end
  end

  assign bus.Phase       = state;
  assign bus.SpawnEnable = spawn;
  assign bus.Speed       = speed;
  assign bus.SecondsLeft = secs;
  assign bus.Winner      = winner;
  assign bus.FinalP1     = fin_p1;
  assign bus.FinalP2     = fin_p2;

endmodule

// File: tb/tb_round_controller.sv
// Scoreboard bench for round_controller with four frames per second.
module tb_round_controller;
  import game_pkg::*;

  typedef struct packed {
    logic [1:0] phase;
    logic       spawn;
    logic [2:0] speed;
    logic [6:0] secs;
    logic [1:0] win;
    logic [6:0] f1;
    logic [6:0] f2;
  } snap_t;

  typedef struct {
    int    frame;
    snap_t s;
  } exp_t;

  logic FrameClk = 1'b0;
  logic ResetN   = 1'b0;
  int   cyc      = 0;
  bit   done     = 1'b0;
  int   checks   = 0;
  int   errors   = 0;
  exp_t q[$];

  round_controller_if bus();

  round_controller #(
    .FRAMES_PER_SEC(4)
  ) dut (
    .FrameClk(FrameClk),
    .ResetN  (ResetN),
    .bus     (bus)
  );

  initial forever #5 FrameClk = ~FrameClk;

  always @(posedge FrameClk) cyc <= cyc + 1;

  function automatic snap_t mk(input int ph, input int sp, input int spd, input int secs,
                               input int w, input int f1, input int f2);
    snap_t s;
    s.phase = 2'(ph);
    s.spawn = 1'(sp);
    s.speed = 3'(spd);
    s.secs  = 7'(secs);
    s.win   = 2'(w);
    s.f1    = 7'(f1);
    s.f2    = 7'(f2);
    return s;
  endfunction

  task automatic push(input int frame, input snap_t s);
    exp_t e;
    e.frame = frame;
    e.s     = s;
    q.push_back(e);
  endtask

  task automatic goto(input int f);
    while (cyc < f) begin
      @(posedge FrameClk);
      #1;
    end
  endtask

  // Monitor: compares the DUT against every expectation due this frame.
  initial begin
    snap_t act;
    exp_t  e;
    forever begin
      @(negedge FrameClk);
      act = {bus.Phase, bus.SpawnEnable, bus.Speed, bus.SecondsLeft,
             bus.Winner, bus.FinalP1, bus.FinalP2};
      while (q.size() > 0 && q[0].frame <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.frame != cyc) begin
          errors++;
          $display("FAIL stale expectation frame=%0d seen at frame=%0d", e.frame, cyc);
        end else if (act !== e.s) begin
          errors++;
          $display("FAIL snap@%0d got ph=%0d sp=%0b spd=%0d sec=%0d win=%b f1=%0d f2=%0d want ph=%0d sp=%0b spd=%0d sec=%0d win=%b f1=%0d f2=%0d",
                   cyc, act.phase, act.spawn, act.speed, act.secs, act.win, act.f1, act.f2,
                   e.s.phase, e.s.spawn, e.s.speed, e.s.secs, e.s.win, e.s.f1, e.s.f2);
        end
      end
      if (done) begin
        if (q.size() != 0) begin
          checks++;
          errors++;
          $display("FAIL leftover expectations got %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog frame=%0d want finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    bus.Start   = 1'b0;
    bus.P1Score = 7'd0;
    bus.P2Score = 7'd0;
    ResetN      = 1'b0;
    @(posedge FrameClk);
    #1;
    push(cyc, mk(TITLE, 0, 4, 0, WIN_NONE, 0, 0));
    goto(cyc + 1);
    ResetN = 1'b1;
    push(cyc + 1, mk(TITLE, 0, 4, 0, WIN_NONE, 0, 0));
    goto(cyc + 2);

    // Held Start, full countdown, full round to timer expiry, GameOver timeout.
    b = cyc;
    bus.P1Score = 7'd12;
    bus.P2Score = 7'd7;
    push(b + 1,   mk(COUNTDOWN, 0, 4, 3,  WIN_NONE, 0, 0));
    push(b + 4,   mk(COUNTDOWN, 0, 4, 3,  WIN_NONE, 0, 0));
    push(b + 5,   mk(COUNTDOWN, 0, 4, 2,  WIN_NONE, 0, 0));
    push(b + 9,   mk(COUNTDOWN, 0, 4, 1,  WIN_NONE, 0, 0));
    push(b + 12,  mk(COUNTDOWN, 0, 4, 1,  WIN_NONE, 0, 0));
    push(b + 13,  mk(PLAY,      1, 4, 90, WIN_NONE, 0, 0));
    push(b + 17,  mk(PLAY,      1, 4, 89, WIN_NONE, 0, 0));
    push(b + 69,  mk(PLAY,      1, 4, 76, WIN_NONE, 0, 0));
    push(b + 132, mk(PLAY,      1, 4, 61, WIN_NONE, 0, 0));
    push(b + 133, mk(PLAY,      1, 5, 60, WIN_NONE, 0, 0));
    push(b + 253, mk(PLAY,      1, 6, 30, WIN_NONE, 0, 0));
    push(b + 369, mk(PLAY,      1, 6, 1,  WIN_NONE, 0, 0));
    push(b + 373, mk(GAMEOVER,  0, 7, 10, WIN_P1,  12, 7));
    push(b + 377, mk(GAMEOVER,  0, 7, 9,  WIN_P1,  12, 7));
    push(b + 409, mk(GAMEOVER,  0, 7, 1,  WIN_P1,  12, 7));
    push(b + 413, mk(TITLE,     0, 7, 0,  WIN_P1,  12, 7));
    bus.Start = 1'b1;
    goto(b + 20);  bus.Start = 1'b0;
    goto(b + 63);  bus.Start = 1'b1;
    goto(b + 65);  bus.Start = 1'b0;
    goto(b + 373); bus.P1Score = 7'd0; bus.P2Score = 7'd0;
    goto(b + 413);

    // Early win by P2, then rematch from GameOver ending on a 99/99 tie.
    b = cyc;
    bus.P1Score = 7'd50;
    bus.P2Score = 7'd98;
    push(b + 1,  mk(COUNTDOWN, 0, 4, 3,  WIN_NONE, 0,  0));
    push(b + 13, mk(PLAY,      1, 4, 90, WIN_NONE, 0,  0));
    push(b + 33, mk(PLAY,      1, 4, 85, WIN_NONE, 0,  0));
    push(b + 34, mk(GAMEOVER,  0, 4, 10, WIN_P2,   50, 99));
    push(b + 46, mk(GAMEOVER,  0, 4, 7,  WIN_P2,   50, 99));
    push(b + 47, mk(COUNTDOWN, 0, 4, 3,  WIN_NONE, 0,  0));
    push(b + 59, mk(PLAY,      1, 4, 90, WIN_NONE, 0,  0));
    push(b + 60, mk(GAMEOVER,  0, 4, 10, WIN_TIE,  99, 99));
    bus.Start = 1'b1;
    goto(b + 2);  bus.Start = 1'b0;
    goto(b + 33); bus.P2Score = 7'd99;
    goto(b + 46); bus.P1Score = 7'd99; bus.Start = 1'b1;
    goto(b + 48); bus.Start = 1'b0;
    goto(b + 60);

    // Rematch, ramp to Speed 5, then asynchronous reset in the middle of Play.
    b = cyc;
    bus.P1Score = 7'd10;
    bus.P2Score = 7'd20;
    push(b + 1,   mk(COUNTDOWN, 0, 4, 3,  WIN_NONE, 0, 0));
    push(b + 13,  mk(PLAY,      1, 4, 90, WIN_NONE, 0, 0));
    push(b + 132, mk(PLAY,      1, 4, 61, WIN_NONE, 0, 0));
    push(b + 133, mk(TITLE,     0, 4, 0,  WIN_NONE, 0, 0));
    push(b + 136, mk(TITLE,     0, 4, 0,  WIN_NONE, 0, 0));
    bus.Start = 1'b1;
    goto(b + 2);   bus.Start = 1'b0;
    goto(b + 133); ResetN = 1'b0;
    goto(b + 135); ResetN = 1'b1;
    goto(b + 137);
    done = 1'b1;
  end

endmodule
